icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 207 ++++++++++++++++++++
 tb/tb_icache.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-stage / memory-controller bundle for icache; the cache uses the slave modport.
interface icache_if;
    logic        IF_pc_sgn;
    logic [31:0] IF_pc;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        ROB_jp_wrong;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_data;

    modport master (
        output IF_pc_sgn, IF_pc, ROB_jp_wrong, MC_done, MC_data,
        input  IF_ins_sgn, IF_ins, MC_req, MC_addr
    );

    modport slave (
        input  IF_pc_sgn, IF_pc, ROB_jp_wrong, MC_done, MC_data,
        output IF_ins_sgn, IF_ins, MC_req, MC_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with line refill from a one-word-at-a-time memory controller.
// Optional macro ICACHE_BYPASS_EN removes line storage and turns every fetch into a single-word read.
module icache #(
    parameter int INDEX_W = 6,
    parameter int OFFS_W  = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    icache_if.slave bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFS_W;
    localparam int TAG_W = 32 - INDEX_W - OFFS_W - 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [OFFS_W-1:0] CNT_ONE = OFFS_W'(1);

    logic [1:0]         state_q, state_d;
    logic               flush_q, flush_d;
    logic               ins_sgn_q, ins_sgn_d;
    logic [31:0]        ins_q, ins_d;
    logic               mc_req_q, mc_req_d;
    logic [31:0]        mc_addr_q, mc_addr_d;
    logic [INDEX_W-1:0] req_idx_q, req_idx_d;
    logic [OFFS_W-1:0]  req_off_q, req_off_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [OFFS_W-1:0]  cnt_q, cnt_d;

    logic [INDEX_W-1:0] pc_idx_s;
    logic [OFFS_W-1:0]  pc_off_s;
    logic [TAG_W-1:0]   pc_tag_s;
    logic               hit_s;
    logic               last_word_s;
    logic [31:0]        hit_word_s;
    logic [31:0]        resp_word_s;
    logic [31:0]        fill_base_s;
    logic               data_we_s;
    logic               tag_we_s;
    logic               line_clr_s;
    logic               pc_unused_s;

    assign pc_off_s    = bus.IF_pc[OFFS_W+1:2];
    assign pc_idx_s    = bus.IF_pc[INDEX_W+OFFS_W+1:OFFS_W+2];
    assign pc_tag_s    = bus.IF_pc[31:INDEX_W+OFFS_W+2];
    assign pc_unused_s = ^bus.IF_pc[1:0];

`ifdef ICACHE_BYPASS_EN
    assign hit_s       = 1'b0;
    assign hit_word_s  = 32'd0;
    assign last_word_s = 1'b1;
    assign resp_word_s = bus.MC_data;
    assign fill_base_s = {bus.IF_pc[31:2], 2'b00};
`else
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    assign hit_s       = valid_q[pc_idx_s] && (tag_q[pc_idx_s] == pc_tag_s);
    assign hit_word_s  = data_q[pc_idx_s][pc_off_s];
    assign last_word_s = (cnt_q == {OFFS_W{1'b1}});
    // The requested word may be the one arriving right now on the final transfer.
    assign resp_word_s = (req_off_q == cnt_q) ? bus.MC_data : data_q[req_idx_q][req_off_q];
    assign fill_base_s = {bus.IF_pc[31:OFFS_W+2], {OFFS_W{1'b0}}, 2'b00};

    // Line valid bits: dropped when a refill starts, set once the last word lands.
    always_comb begin
        valid_d = valid_q;
        if (line_clr_s) begin
            valid_d[pc_idx_s] = 1'b0;
        end else if (tag_we_s) begin
            valid_d[req_idx_q] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bit register, cleared by reset so a half-filled line is never trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage writes.
    always_ff @(posedge clk) begin
        if (!rst && data_we_s) begin
            data_q[req_idx_q][cnt_q] <= bus.MC_data;
        end
        if (!rst && tag_we_s) begin
            tag_q[req_idx_q] <= req_tag_q;
        end
    end
`endif

    // Next-state logic for the IDLE / REFILL / RESP controller.
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        ins_sgn_d  = ins_sgn_q;
        ins_d      = ins_q;
        mc_req_d   = mc_req_q;
        mc_addr_d  = mc_addr_q;
        req_idx_d  = req_idx_q;
        req_off_d  = req_off_q;
        req_tag_d  = req_tag_q;
        cnt_d      = cnt_q;
        data_we_s  = 1'b0;
        tag_we_s   = 1'b0;
        line_clr_s = 1'b0;
        if (rdy) begin
            ins_sgn_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A pulse cycle also blocks acceptance so IF_ins_sgn never repeats back-to-back.
                    if (bus.IF_pc_sgn && !bus.ROB_jp_wrong && !ins_sgn_q) begin
                        if (hit_s) begin
                            ins_sgn_d = 1'b1;
                            ins_d     = hit_word_s;
                        end else begin
                            state_d    = ST_REFILL;
                            flush_d    = 1'b0;
                            mc_req_d   = 1'b1;
                            mc_addr_d  = fill_base_s;
                            cnt_d      = {OFFS_W{1'b0}};
                            req_idx_d  = pc_idx_s;
                            req_off_d  = pc_off_s;
                            req_tag_d  = pc_tag_s;
                            line_clr_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REFILL: begin
                    flush_d = flush_q | bus.ROB_jp_wrong;
                    if (bus.MC_done) begin
                        data_we_s = 1'b1;
                        if (last_word_s) begin
                            tag_we_s = 1'b1;
                            mc_req_d = 1'b0;
                            if (flush_q || bus.ROB_jp_wrong) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d   = ST_RESP;
                                ins_sgn_d = 1'b1;
                                ins_d     = resp_word_s;
                            end
                        end else begin
                            cnt_d     = cnt_q + CNT_ONE;
                            mc_addr_d = mc_addr_q + 32'd4;
                        end
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Controller and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flush_q   <= 1'b0;
            ins_sgn_q <= 1'b0;
            ins_q     <= 32'd0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= 32'd0;
            req_idx_q <= {INDEX_W{1'b0}};
            req_off_q <= {OFFS_W{1'b0}};
            req_tag_q <= {TAG_W{1'b0}};
            cnt_q     <= {OFFS_W{1'b0}};
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            ins_sgn_q <= ins_sgn_d;
            ins_q     <= ins_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            req_tag_q <= req_tag_d;
            cnt_q     <= cnt_d;
        end
    end

    // A flush arriving while the pulse is on the wire (hit delivery or RESP) still kills it.
    assign bus.IF_ins_sgn = ins_sgn_q & ~bus.ROB_jp_wrong;
    assign bus.IF_ins     = ins_q;
    assign bus.MC_req     = mc_req_q;
    assign bus.MC_addr    = mc_addr_q;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a line-level cache model predicts every output cycle.
module tb_icache;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus();

    icache #(.INDEX_W(6), .OFFS_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_en   = 1'b0;
    logic        exp_sgn  = 1'b0;
    logic        exp_req  = 1'b0;
    logic [31:0] exp_ins  = 32'd0;
    logic [31:0] exp_addr = 32'd0;
    logic        m_valid [64];
    logic [21:0] m_tag   [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:16] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("if_ins_sgn", {31'd0, bus.IF_ins_sgn}, {31'd0, exp_sgn});
            if (exp_sgn) chk("if_ins", bus.IF_ins, exp_ins);
            chk("mc_req", {31'd0, bus.MC_req}, {31'd0, exp_req});
            if (exp_req) chk("mc_addr", bus.MC_addr, exp_addr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // fl: 0 plain, 1 flush mid-refill, 2 flush with request, 3 flush in pulse cycle,
    //     4 rdy low for 5 cycles at start of refill, 5 reset after second word.
    task automatic fetch(input logic [31:0] pc, input int fl);
        logic [5:0]  idx;
        logic [21:0] tag;
        logic [31:0] base;
        logic        hit;
        idx  = pc[9:4];
        tag  = pc[31:10];
        base = {pc[31:4], 4'h0};
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        bus.IF_pc        = pc;
        bus.IF_pc_sgn    = 1'b1;
        bus.ROB_jp_wrong = (fl == 2);
        cyc();
        bus.IF_pc_sgn    = 1'b0;
        bus.ROB_jp_wrong = 1'b0;
        if (fl == 2) begin
            exp_sgn = 1'b0;
            exp_req = 1'b0;
            cyc();
            return;
        end
        if (hit) begin
            exp_sgn = (fl != 3);
            exp_ins = mem_word({pc[31:2], 2'b00});
            exp_req = 1'b0;
            bus.ROB_jp_wrong = (fl == 3);
            cyc();
            bus.ROB_jp_wrong = 1'b0;
            exp_sgn = 1'b0;
            return;
        end
        exp_sgn  = 1'b0;
        exp_req  = 1'b1;
        exp_addr = base;
        for (int w = 0; w < 4; w++) begin
            if (w == 0 && fl == 4) begin
                rdy = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    bus.MC_done = (k == 2);
                    bus.MC_data = 32'hDEAD_0000;
                    cyc();
                end
                bus.MC_done = 1'b0;
                rdy = 1'b1;
            end
            for (int l = 0; l < LAT; l++) begin
                bus.MC_done      = (l == LAT - 1);
                bus.MC_data      = (l == LAT - 1) ? mem_word(base + 32'(4 * w)) : 32'd0;
                bus.ROB_jp_wrong = (fl == 1 && w == 1 && l == 0);
                cyc();
                bus.MC_done      = 1'b0;
                bus.ROB_jp_wrong = 1'b0;
                if (l == LAT - 1) begin
                    if (w < 3) begin
                        exp_addr = base + 32'(4 * (w + 1));
                    end else begin
                        exp_req = 1'b0;
                        exp_sgn = (fl == 0 || fl == 4);
                        exp_ins = mem_word({pc[31:2], 2'b00});
                        bus.ROB_jp_wrong = (fl == 3);
                    end
                end
            end
            if (fl == 5 && w == 1) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                exp_req = 1'b0;
                exp_sgn = 1'b0;
                chk("rst_mid_refill_req", {31'd0, bus.MC_req}, 32'd0);
                chk("rst_mid_refill_ins", bus.IF_ins, 32'd0);
                for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
                cyc();
                return;
            end
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        cyc();
        bus.ROB_jp_wrong = 1'b0;
        exp_sgn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.IF_pc_sgn    = 1'b0;
        bus.IF_pc        = 32'd0;
        bus.ROB_jp_wrong = 1'b0;
        bus.MC_done      = 1'b0;
        bus.MC_data      = 32'd0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 22'd0;
        end
        cyc();
        cyc();
        chk("reset_ins_sgn", {31'd0, bus.IF_ins_sgn}, 32'd0);
        chk("reset_ins", bus.IF_ins, 32'd0);
        chk("reset_mc_req", {31'd0, bus.MC_req}, 32'd0);
        chk("reset_mc_addr", bus.MC_addr, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        fetch(32'h0000_0000, 0);
        chk("miss_0x0_word", bus.IF_ins, 32'hBEEF_1234);
        fetch(32'h0000_0008, 0);
        chk("hit_0x8_word", bus.IF_ins, 32'hBEEF_123C);
        fetch(32'h0000_0400, 0);
        chk("conflict_0x400_word", bus.IF_ins, 32'hBEEF_1634);
        fetch(32'h0000_0000, 0);
        chk("refetch_0x0_word", bus.IF_ins, 32'hBEEF_1234);

        fetch(32'h0000_0020, 1);
        chk("flushed_refill_no_update", bus.IF_ins, 32'hBEEF_1234);
        fetch(32'h0000_0024, 0);
        chk("hit_0x24_word", bus.IF_ins, 32'hBEEF_1210);

        fetch(32'h0000_0008, 2);
        fetch(32'h0000_0008, 3);
        fetch(32'h0000_0200, 3);
        fetch(32'h0000_0204, 0);
        chk("hit_0x204_word", bus.IF_ins, 32'hBEEF_1030);

        fetch(32'h0000_0100, 4);
        chk("rdy_freeze_0x100_word", bus.IF_ins, 32'hBEEF_1334);

        fetch(32'h0000_0080, 5);
        fetch(32'h0000_0080, 0);
        chk("refill_after_rst_word", bus.IF_ins, 32'hBEEF_12B4);
        fetch(32'h0000_0008, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
